// File: rtl/paddle_ctrl.sv
// rtl/paddle_ctrl.sv - button levels to clamped paddle row with tap step and auto-repeat (option macro: PADDLE_ACCEL_EN)
module paddle_ctrl #(
  parameter int TICK_DIV      = 50000,
  parameter int REPEAT_DELAY  = 200,
  parameter int REPEAT_PERIOD = 10,
  parameter int STEP          = 4,
  parameter int Y_MAX         = 400,
  parameter int Y_INIT        = 200,
  parameter int ACCEL_AFTER   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       up_click,
  input  logic       down_click,
  output logic [9:0] paddle_y,
  output logic       moving,
  output logic       at_limit
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = 16;
  localparam logic [PW-1:0] TICK_LAST   = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] DELAY_LAST  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PERIOD_LAST = CW'(REPEAT_PERIOD - 1);
  localparam logic [9:0]    Y_INIT_V    = 10'(Y_INIT);
  localparam logic [9:0]    Y_MAX_V     = 10'(Y_MAX);
  localparam logic          LIMIT_INIT  = (Y_INIT == 0) || (Y_INIT == Y_MAX);

  typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DOWN} dir_t;
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  logic          up_s1, up_s2, dn_s1, dn_s2;
  dir_t          dir, dir_q;
  state_t        state;
  logic [PW-1:0] presc;
  logic          tick;
  logic [CW-1:0] tick_cnt;
  logic          dir_change;
  logic [10:0]   step_size;
  logic [9:0]    y_step;

  // Clamped position after one step; 11-bit math keeps the sum and difference from wrapping
  function automatic logic [9:0] step_y(input logic [9:0] y, input dir_t d, input logic [10:0] s);
    logic [10:0] w;
    w = {1'b0, y};
    if (d == DIR_UP) return (w < s) ? 10'd0 : 10'(w - s);
    else             return ((w + s) > {1'b0, Y_MAX_V}) ? Y_MAX_V : 10'(w + s);
  endfunction

  // Two-flop synchronizers for the levels coming from the 1 ms debouncer domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_s1 <= 1'b0;
      up_s2 <= 1'b0;
      dn_s1 <= 1'b0;
      dn_s2 <= 1'b0;
    end else begin
      up_s1 <= up_click;
      up_s2 <= up_s1;
      dn_s1 <= down_click;
      dn_s2 <= dn_s1;
    end
  end

  // Direction decode: both or neither pressed means no motion
  always_comb begin
    dir = DIR_NONE;
    if (up_s2 && !dn_s2)      dir = DIR_UP;
    else if (dn_s2 && !up_s2) dir = DIR_DOWN;
  end

  // Free-running prescaler; tick phase is independent of button activity
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + PW'(1);
  end

  assign tick       = (presc == TICK_LAST);
  assign dir_change = (dir != dir_q);

`ifdef PADDLE_ACCEL_EN
  localparam logic [7:0] ACCEL_LAST = 8'(ACCEL_AFTER);
  logic [7:0] rep_cnt;
  logic       rep_step;

  assign rep_step  = (state == REPEAT) && !dir_change && tick && (tick_cnt == PERIOD_LAST);
  assign step_size = ((state == REPEAT) && (rep_cnt >= ACCEL_LAST)) ? 11'(2 * STEP) : 11'(STEP);

  // Counts repeat steps taken in REPEAT, saturating once the doubled step is reached
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 rep_cnt <= '0;
    else if (state != REPEAT || dir_change)     rep_cnt <= '0;
    else if (rep_step && rep_cnt != ACCEL_LAST) rep_cnt <= rep_cnt + 8'd1;
  end
`else
  assign step_size = 11'(STEP);
`endif

  assign y_step = step_y(paddle_y, dir, step_size);

  // Motion FSM with registered position, moving and limit flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      dir_q    <= DIR_NONE;
      tick_cnt <= '0;
      paddle_y <= Y_INIT_V;
      moving   <= 1'b0;
      at_limit <= LIMIT_INIT;
    end else begin
      case (state)
        IDLE: begin
          if (dir != DIR_NONE) begin
            paddle_y <= y_step;
            at_limit <= (y_step == 10'd0) || (y_step == Y_MAX_V);
            dir_q    <= dir;
            tick_cnt <= '0;
            state    <= DELAY;
            moving   <= 1'b1;
          end
        end
        DELAY: begin
          if (dir_change) begin
            state    <= IDLE;
            tick_cnt <= '0;
            moving   <= 1'b0;
          end else if (tick) begin
            if (tick_cnt == DELAY_LAST) begin
              paddle_y <= y_step;
              at_limit <= (y_step == 10'd0) || (y_step == Y_MAX_V);
              tick_cnt <= '0;
              state    <= REPEAT;
            end else begin
              tick_cnt <= tick_cnt + CW'(1);
            end
          end
        end
        REPEAT: begin
          if (dir_change) begin
            state    <= IDLE;
            tick_cnt <= '0;
            moving   <= 1'b0;
          end else if (tick) begin
            if (tick_cnt == PERIOD_LAST) begin
              paddle_y <= y_step;
              at_limit <= (y_step == 10'd0) || (y_step == Y_MAX_V);
              tick_cnt <= '0;
            end else begin
              tick_cnt <= tick_cnt + CW'(1);
            end
          end
        end
        default: begin
          state    <= IDLE;
          tick_cnt <= '0;
          moving   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/paddle_ctrl.md
# paddle_ctrl

Converts the debounced up/down button levels of one player into a clamped vertical paddle position for the PONG playfield. Sits directly downstream of the two debouncers for that player, which deliver their levels from the 1 ms domain. Upstream of the renderer and collision logic. A tap moves the paddle one step. A held button moves it again after a delay, then auto-repeats at a fixed rate.

## Interface
- TICK_DIV, 50000: clk cycles per internal tick (1 ms at 50 MHz).
- REPEAT_DELAY, 200: ticks from the first step to the first repeat step.
- REPEAT_PERIOD, 10: ticks between repeat steps.
- STEP, 4: pixels per step.
- Y_MAX, 400: largest paddle_y value (480 − paddle height 80).
- Y_INIT, 200: paddle_y after reset.
- ACCEL_AFTER, 8: repeat steps before acceleration. Used only with PADDLE_ACCEL_EN.
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- up_click  in  1  debounced up level. Asynchronous to clk.
- down_click  in  1  debounced down level. Asynchronous to clk.
- paddle_y  out  10  paddle top row, 0..Y_MAX, registered.
- moving  out  1  high while the FSM is outside IDLE, registered.
- at_limit  out  1  high when paddle_y is 0 or Y_MAX, registered.

## Operation
- Each input passes through a two-flop synchronizer (reset 0).
- Direction decode uses the second synchronizer flop:
  - up only → UP.
  - down only → DOWN.
  - both or neither → NONE.
- Prescaler: free-running counter 0..TICK_DIV−1, reset 0. A one-cycle tick is asserted when the counter equals TICK_DIV−1.
- FSM states: IDLE, DELAY, REPEAT.
  - A direction register latches dir on entry to DELAY.
  - A tick counter is cleared on every state change.
- IDLE: when dir ≠ NONE, apply one step in dir, latch dir, go to DELAY.
- DELAY: count ticks. On the REPEAT_DELAY-th tick, step and go to REPEAT.
- REPEAT: on every REPEAT_PERIOD-th tick, step and restart the count.
- In DELAY or REPEAT, dir ≠ latched dir (release, reversal, or both pressed) → IDLE with no step. A reversal therefore starts on the following cycle.
- Step arithmetic uses 11-bit intermediates:
  - UP: y < STEP → 0, else y − STEP.
  - DOWN: y > Y_MAX − STEP → Y_MAX, else y + STEP.
- Steps at a limit leave paddle_y unchanged. The FSM still runs.
- at_limit is computed from the next value of paddle_y and registered on the same edge.
- Reset values:
  - paddle_y = Y_INIT; at_limit = (Y_INIT == 0 || Y_INIT == Y_MAX); moving = 0.
  - State IDLE; prescaler, tick counter, and synchronizers all 0.
- Reset asserted mid-motion restores the reset values immediately, without waiting for clk.

## Timing
- Input level present before edge k → second synchronizer flop valid after edge k+1 → first step visible after edge k+2. moving rises on that same edge.
- Release before edge k → FSM in IDLE and moving = 0 after edge k+2.
- Prescaler runs independently of the FSM. The first tick in DELAY comes 1..TICK_DIV cycles after entry, so jitter is at most one tick; this is accepted.
- Tick coincident with a direction change: the change wins and no step is taken.

## Configuration
- PADDLE_ACCEL_EN defined:
  - In REPEAT, a counter of repeat steps runs from entry.
  - After ACCEL_AFTER repeat steps, the step size becomes 2·STEP with the same clamping.
  - Leaving REPEAT restores STEP and clears the counter.
- Not defined: step size is always STEP and ACCEL_AFTER is ignored.

## Test plan
Bench overrides: TICK_DIV=4, REPEAT_DELAY=3, REPEAT_PERIOD=2, STEP=4, Y_MAX=40, Y_INIT=20, ACCEL_AFTER=2.
- Reset: outputs are paddle_y=20, moving=0, at_limit=0. Then hold up and drop rst_n in REPEAT between edges → paddle_y=20 and moving=0 before the next edge.
- Tap down for 5 cycles → paddle_y=24 exactly 2 edges after the rise. No further change. moving falls 2 edges after release.
- Hold up:
  - 16 at entry.
  - 12 on the 3rd tick after entry.
  - Then 8, 4, 0 every 2 ticks.
  - at_limit=1 from 0 on; further ticks leave paddle_y at 0.
- Up and down together from IDLE → no change and moving=0. Hold up into REPEAT, then switch to down → one IDLE cycle, then paddle_y +4 on the next edge.
- Y_INIT=18, hold down → 22, 26, …, 38, then 40 (clamped), at_limit=1.
- Y_INIT=0, hold down for 14 ticks → 4, 8, 12, 16, then:
  - with PADDLE_ACCEL_EN: 24, 32, 40.
  - without PADDLE_ACCEL_EN: 20, 24, 28.
